// File: rtl/fp_add_sequencer.sv
// Register-file to FP-adder command sequencer: reads two operands, waits ADD_LAT cycles, writes the sum back.
// Optional FPSEQ_EXC_FLAG_EN adds the exc flag and a saturating exc_count of Inf/NaN completions.
module fp_add_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic              rf_we,
  output logic              rf_mode,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic [DATA_W-1:0] add_sum,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] done_dst,
  output logic [DATA_W-1:0] done_data
`ifdef FPSEQ_EXC_FLAG_EN
  ,
  output logic              exc,
  output logic [7:0]        exc_count
`endif
);

  localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, ADD, WB} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  src_a, src_b, dst;
  logic [DATA_W-1:0]  op_a, op_b, res;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      src_a <= '0;
      src_b <= '0;
      dst   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      cnt   <= '0;
`ifdef FPSEQ_EXC_FLAG_EN
      exc_count <= '0;
`endif
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (cmd_valid) begin
          src_a <= cmd_src_a;
          src_b <= cmd_src_b;
          dst   <= cmd_dst;
        end
        // Read data lags the address by one cycle, so A lands during RD_B and B during CAP_B.
        RD_B:  op_a <= rf_rdata;
        CAP_B: begin
          op_b <= rf_rdata;
          cnt  <= CNT_W'(ADD_LAT - 1);
        end
        ADD: begin
          if (cnt == '0) res <= add_sum;
          else           cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
`ifdef FPSEQ_EXC_FLAG_EN
      if (state == WB && res[30:23] == 8'hFF && exc_count != 8'hFF)
        exc_count <= exc_count + 8'd1;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    rf_we     = 1'b0;
    rf_mode   = 1'b1;
    rf_addr   = '0;
    rf_wdata  = '0;
    done      = 1'b0;
    done_dst  = '0;
    done_data = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = RD_A;
      end
      RD_A: begin
        rf_addr = src_a;
        state_n = RD_B;
      end
      RD_B: begin
        rf_addr = src_b;
        state_n = CAP_B;
      end
      CAP_B: state_n = ADD;
      ADD:   if (cnt == '0) state_n = WB;
      WB: begin
        rf_we     = 1'b1;
        rf_mode   = 1'b0;
        rf_addr   = dst;
        rf_wdata  = res;
        done      = 1'b1;
        done_dst  = dst;
        done_data = res;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Reset gates the outputs in the same cycle, so a WB caught by reset never writes.
    if (!reset) begin
      cmd_ready = 1'b0;
      rf_we     = 1'b0;
      rf_mode   = 1'b1;
      rf_addr   = '0;
      rf_wdata  = '0;
      done      = 1'b0;
      done_dst  = '0;
      done_data = '0;
    end
  end

  assign busy  = reset && (state != IDLE);
  assign add_a = reset ? op_a : '0;
  assign add_b = reset ? op_b : '0;

`ifdef FPSEQ_EXC_FLAG_EN
  assign exc = done && (res[30:23] == 8'hFF);
`endif

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: two instances (ADD_LAT 1 and 3) with register-file and adder models.
// Checks per-cycle sequencing against a reference of register contents computed with a behavioural FP add.
module tb_fp_add_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  cmd_src_a, cmd_src_b, cmd_dst;
  logic        v1, v3;

  logic        cmd_ready1, rf_we1, rf_mode1, busy1, done1;
  logic [4:0]  rf_addr1, done_dst1;
  logic [31:0] rf_wdata1, rdata1, add_a1, add_b1, add_sum1, done_data1;
  logic        cmd_ready3, rf_we3, rf_mode3, busy3, done3;
  logic [4:0]  rf_addr3, done_dst3;
  logic [31:0] rf_wdata3, rdata3, add_a3, add_b3, add_sum3, done_data3;
  logic [31:0] s3c, s3p1, s3p2;
`ifdef FPSEQ_EXC_FLAG_EN
  logic        exc1, exc3;
  logic [7:0]  exc_count1, exc_count3;
`endif

  int checks = 0;
  int failures = 0;

  // Round-to-nearest-even single-precision add done on an exact wide integer sum.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [279:0] A, B, S, m, rem, half;
    int ea, eb, e, p, sh, ex;
    logic s;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
    ea = (a[30:23] == 8'h00) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'h00) ? 1 : int'(b[30:23]);
    A  = (a[30:23] == 8'h00) ? 280'(0) : 280'({1'b1, a[22:0]});
    B  = (b[30:23] == 8'h00) ? 280'(0) : 280'({1'b1, b[22:0]});
    e  = (ea < eb) ? ea : eb;
    A  = A << (ea - e);
    B  = B << (eb - e);
    if (a[31] == b[31]) begin S = A + B; s = a[31]; end
    else if (A >= B)    begin S = A - B; s = a[31]; end
    else                begin S = B - A; s = b[31]; end
    if (S == 280'(0)) return 32'h0;
    p = 0;
    for (int i = 0; i < 280; i++) if (S[i]) p = i;
    if (p > 23) begin
      sh   = p - 23;
      m    = S >> sh;
      half = 280'(1) << (sh - 1);
      rem  = S & ((280'(1) << sh) - 280'(1));
      if (rem > half || (rem == half && m[0])) m = m + 280'(1);
      if (m[24]) begin m = m >> 1; sh++; end
      ex = e + sh;
    end else begin
      m  = S << (23 - p);
      ex = e - (23 - p);
    end
    if (ex >= 255) return {s, 8'hFF, 23'h0};
    if (ex <= 0)   return {s, 31'h0};
    return {s, ex[7:0], m[22:0]};
  endfunction

  assign add_sum1 = fadd(add_a1, add_b1);
  assign s3c      = fadd(add_a3, add_b3);
  assign add_sum3 = s3p2;
  always @(posedge clk) begin
    s3p1 <= s3c;
    s3p2 <= s3p1;
  end

  logic [31:0] rfm [2][32];
  logic        ld_en, ld_sel;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  always @(posedge clk) begin
    if (ld_en) rfm[ld_sel][ld_addr] <= ld_data;
    else begin
      if (rf_we1 && !rf_mode1) rfm[0][rf_addr1] <= rf_wdata1;
      if (rf_we3 && !rf_mode3) rfm[1][rf_addr3] <= rf_wdata3;
    end
    if (rf_mode1) rdata1 <= rfm[0][rf_addr1];
    if (rf_mode3) rdata3 <= rfm[1][rf_addr3];
  end

  fp_add_sequencer #(.ADDR_W(5), .DATA_W(32), .ADD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_ready(cmd_ready1),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .rf_we(rf_we1), .rf_mode(rf_mode1), .rf_addr(rf_addr1), .rf_wdata(rf_wdata1),
    .rf_rdata(rdata1), .add_a(add_a1), .add_b(add_b1), .add_sum(add_sum1),
    .busy(busy1), .done(done1), .done_dst(done_dst1), .done_data(done_data1)
`ifdef FPSEQ_EXC_FLAG_EN
    , .exc(exc1), .exc_count(exc_count1)
`endif
  );

  fp_add_sequencer #(.ADDR_W(5), .DATA_W(32), .ADD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_ready(cmd_ready3),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .rf_we(rf_we3), .rf_mode(rf_mode3), .rf_addr(rf_addr3), .rf_wdata(rf_wdata3),
    .rf_rdata(rdata3), .add_a(add_a3), .add_b(add_b3), .add_sum(add_sum3),
    .busy(busy3), .done(done3), .done_dst(done_dst3), .done_data(done_data3)
`ifdef FPSEQ_EXC_FLAG_EN
    , .exc(exc3), .exc_count(exc_count3)
`endif
  );

  logic        sel;
  logic        o_ready, o_we, o_mode, o_busy, o_done;
  logic [4:0]  o_addr, o_ddst;
  logic [31:0] o_wdata, o_a, o_b, o_ddata;
  assign o_ready = sel ? cmd_ready3 : cmd_ready1;
  assign o_we    = sel ? rf_we3     : rf_we1;
  assign o_mode  = sel ? rf_mode3   : rf_mode1;
  assign o_busy  = sel ? busy3      : busy1;
  assign o_done  = sel ? done3      : done1;
  assign o_addr  = sel ? rf_addr3   : rf_addr1;
  assign o_ddst  = sel ? done_dst3  : done_dst1;
  assign o_wdata = sel ? rf_wdata3  : rf_wdata1;
  assign o_a     = sel ? add_a3     : add_a1;
  assign o_b     = sel ? add_b3     : add_b1;
  assign o_ddata = sel ? done_data3 : done_data1;
`ifdef FPSEQ_EXC_FLAG_EN
  logic       o_exc;
  logic [7:0] o_xcnt;
  assign o_exc  = sel ? exc3 : exc1;
  assign o_xcnt = sel ? exc_count3 : exc_count1;
`endif

  logic [31:0] refm [2][32];
  int          xcm [2];

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic load(input logic s, input logic [4:0] a, input logic [31:0] d);
    ld_sel = s; ld_addr = a; ld_data = d; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
    refm[s][a] = d;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(118, 137));
    return r;
  endfunction

  task automatic run_cmd(input logic s, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic hold, input logic [4:0] na, input logic [4:0] nb, input logic [4:0] nd,
                         input logic rst_wb);
    int n, lat;
    logic [31:0] expv, opa, opb;
    sel = s;
    lat = s ? 3 : 1;
    cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
    if (s) v3 = 1'b1; else v1 = 1'b1;
    #1;
    n = 0;
    while (!o_ready && n < 20) begin @(negedge clk); n++; end
    chk1("accept_ready", o_ready, 1'b1);
    opa  = refm[s][a];
    opb  = refm[s][b];
    expv = fadd(opa, opb);
    @(posedge clk); #1;
    if (hold) begin
      cmd_src_a = na; cmd_src_b = nb; cmd_dst = nd;
    end else begin
      v1 = 1'b0; v3 = 1'b0;
      cmd_src_a = 5'($urandom); cmd_src_b = 5'($urandom); cmd_dst = 5'($urandom);
    end
    for (int k = 1; k <= 4 + lat; k++) begin
      if (rst_wb && k == 4 + lat) reset = 1'b0;
      @(negedge clk);
      if (rst_wb && k == 4 + lat) begin
        chk1("rst_wb_we", o_we, 1'b0);
        chk1("rst_wb_done", o_done, 1'b0);
        chk1("rst_wb_busy", o_busy, 1'b0);
        chk1("rst_wb_ready", o_ready, 1'b0);
        chk1("rst_wb_mode", o_mode, 1'b1);
        chk32("rst_wb_addr", 32'(o_addr), 32'h0);
        chk32("rst_wb_add_a", o_a, 32'h0);
      end else begin
        chk1("busy", o_busy, 1'b1);
        chk1("ready_busy", o_ready, 1'b0);
        if (k < 4 + lat) begin
          chk1("we_idle", o_we, 1'b0);
          chk1("mode_read", o_mode, 1'b1);
          chk1("done_idle", o_done, 1'b0);
        end
        if (k == 1) chk32("rd_a_addr", 32'(o_addr), 32'(a));
        if (k == 2) chk32("rd_b_addr", 32'(o_addr), 32'(b));
        if (k >= 4 && k < 4 + lat) begin
          chk32("add_a_hold", o_a, opa);
          chk32("add_b_hold", o_b, opb);
        end
        if (k == 4 + lat) begin
          chk1("wb_we", o_we, 1'b1);
          chk1("wb_mode", o_mode, 1'b0);
          chk32("wb_addr", 32'(o_addr), 32'(d));
          chk32("wb_wdata", o_wdata, expv);
          chk1("done", o_done, 1'b1);
          chk32("done_dst", 32'(o_ddst), 32'(d));
          chk32("done_data", o_ddata, expv);
`ifdef FPSEQ_EXC_FLAG_EN
          chk1("exc", o_exc, expv[30:23] == 8'hFF);
`endif
        end
      end
      @(posedge clk); #1;
    end
    if (rst_wb) begin
      reset = 1'b1;
      xcm[0] = 0; xcm[1] = 0;
      v1 = 1'b0; v3 = 1'b0;
      @(negedge clk);
      chk1("ready_after_rst", o_ready, 1'b1);
    end else begin
      refm[s][d] = expv;
      if (expv[30:23] == 8'hFF && xcm[s] < 255) xcm[s]++;
      @(negedge clk);
      chk1("ready_after_wb", o_ready, 1'b1);
      chk1("busy_after_wb", o_busy, 1'b0);
`ifdef FPSEQ_EXC_FLAG_EN
      chk32("exc_count", 32'(o_xcnt), 32'(xcm[s]));
`endif
    end
  endtask

  initial begin
    reset = 1'b0; v1 = 1'b0; v3 = 1'b0; sel = 1'b0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
    ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    xcm[0] = 0; xcm[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk1("rst_ready", o_ready, 1'b0);
      chk1("rst_busy", o_busy, 1'b0);
      chk1("rst_we", o_we, 1'b0);
      chk1("rst_mode", o_mode, 1'b1);
      chk32("rst_addr", 32'(o_addr), 32'h0);
      chk1("rst_done", o_done, 1'b0);
    end
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 32; r++) load(1'(s), 5'(r), rnd_fp());
    reset = 1'b1;
    @(negedge clk);
    sel = 1'b0; #1;
    chk1("ready_out_of_reset", o_ready, 1'b1);
    chk32("idle_add_a", add_a1, 32'h0);
`ifdef FPSEQ_EXC_FLAG_EN
    chk32("rst_exc_count", 32'(exc_count1), 32'h0);
`endif

    load(1'b0, 5'd22, 32'h40B60001);
    load(1'b0, 5'd28, 32'h40B2041B);
    run_cmd(1'b0, 5'd22, 5'd28, 5'd31, 1'b1, 5'd31, 5'd31, 5'd5, 1'b0);
    chk32("tp_rf31", rfm[0][31], 32'h4134020E);
    run_cmd(1'b0, 5'd31, 5'd31, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk32("tp_rf5", rfm[0][5], 32'h41B4020E);

    load(1'b1, 5'd22, 32'h40B60001);
    load(1'b1, 5'd28, 32'h40B2041B);
    run_cmd(1'b1, 5'd22, 5'd28, 5'd31, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk32("lat3_rf31", rfm[1][31], 32'h4134020E);

    load(1'b0, 5'd31, 32'h12345678);
    run_cmd(1'b0, 5'd22, 5'd28, 5'd31, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    chk32("rst_wb_rf31", rfm[0][31], 32'h12345678);

    load(1'b0, 5'd4, 32'h3F800000);
    run_cmd(1'b0, 5'd4, 5'd4, 5'd4, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk32("same_reg_rf4", rfm[0][4], 32'h40000000);

    load(1'b0, 5'd1, 32'h7F7FFFFF);
    load(1'b0, 5'd2, 32'h7F7FFFFF);
    run_cmd(1'b0, 5'd1, 5'd2, 5'd7, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk32("ovf_rf7", rfm[0][7], 32'h7F800000);
    run_cmd(1'b0, 5'd22, 5'd28, 5'd8, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    for (int i = 0; i < 24; i++)
      run_cmd(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 5'($urandom),
              1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    @(posedge clk); #1;
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 32; r++) chk32("rf_final", rfm[s][r], refm[s][r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Command-driven controller between the 32x32 register file and the single-precision floating-point adder.
- Accepts one "dst = src_a + src_b" command at a time through a valid/ready handshake.
- Reads both operands through a single register-file port and presents them to the adder.
- Captures the sum after a fixed adder latency, writes it back to dst, and reports completion.

Parameters:
ADDR_W, 5, register-file address width
DATA_W, 32, operand/result width (IEEE-754 single)
ADD_LAT, 1, cycles operands are held on the adder before the sum is captured (>=1)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous reset, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command
cmd_src_a  in  ADDR_W  first operand register
cmd_src_b  in  ADDR_W  second operand register
cmd_dst  in  ADDR_W  destination register
rf_we  out  1  register-file write enable
rf_mode  out  1  register-file mode: 0 = write, 1 = read
rf_addr  out  ADDR_W  register-file address
rf_wdata  out  DATA_W  register-file write data
rf_rdata  in  DATA_W  register-file read data, valid one cycle after rf_addr with rf_mode=1
add_a  out  DATA_W  adder operand A
add_b  out  DATA_W  adder operand B
add_sum  in  DATA_W  adder result
busy  out  1  command in progress (state != IDLE)
done  out  1  one-cycle pulse on writeback
done_dst  out  ADDR_W  destination of completed command, valid with done
done_data  out  DATA_W  written value, valid with done

Behaviour:
- Reset (reset=0 at posedge): state=IDLE; op_a, op_b, res, latched addresses and counter cleared.
- While reset=0: cmd_ready, rf_we, busy and done are forced 0 combinationally; rf_mode=1; rf_addr, rf_wdata, add_a, add_b, done_dst and done_data are 0.
- States and transitions:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch src_a/src_b/dst, go to RD_A.
  - RD_A: rf_mode=1, rf_addr=src_a; go to RD_B.
  - RD_B: rf_addr=src_b; op_a<=rf_rdata; go to CAP_B.
  - CAP_B: op_b<=rf_rdata; cnt<=ADD_LAT-1; go to ADD.
  - ADD: if cnt==0, res<=add_sum and go to WB; else cnt<=cnt-1. ADD lasts exactly ADD_LAT cycles.
  - WB: rf_we=1, rf_mode=0, rf_addr=dst, rf_wdata=res; done=1, done_dst=dst, done_data=res; go to IDLE.
- add_a=op_a and add_b=op_b at all times; they are stable throughout ADD.
- Latency: command accepted at edge T puts the controller in RD_A for cycle T+1, and done is high in cycle T+4+ADD_LAT.
  - ADD_LAT=1 gives done in T+5; the next accept is possible at the end of cycle T+6.
- rf_we=0 and rf_mode=1 in every state except WB. No write ever occurs outside WB.
- cmd_ready=0 whenever busy. cmd_valid is ignored while busy; the source must hold the command.
- src_a==src_b: still two reads, same value into both operands.
- dst equal to a source: legal, because the write happens after both reads.
- Back-to-back commands where one reads the previous dst see the new value: WB precedes the next RD_A.
- Reset mid-operation: abort to IDLE; the pending write is discarded; no done pulse.
- Reset during WB: rf_we is gated off that cycle, so there is no write.
- Sum arithmetic, rounding and special values are owned by the adder. This block passes bits unmodified.

Optional Feature:
- Macro FPSEQ_EXC_FLAG_EN.
- Defined:
  - Extra output port exc, 1 bit.
  - exc=1 with done when res[30:23]==8'hFF (Inf/NaN result), else 0.
  - Extra output port exc_count, 8 bits, saturating count of such completions, cleared by reset.
- Not defined: neither port exists; behaviour otherwise identical.

Test Plan:
- rf[22]=0x40B60001, rf[28]=0x40B2041B, bench adder model, ADD_LAT=1, cmd src_a=22 src_b=28 dst=31 accepted at T -> rf_addr sequence 22,28 in T+1/T+2; done in T+5 with done_dst=31 and done_data=0x4134020E; rf[31]=0x4134020E.
- cmd_valid held high with a second command (src 31, src 31, dst 5) during the first -> cmd_ready=0 until IDLE; second accepted at the end of T+6; done_data=0x41B4020E.
- ADD_LAT=3, same first command -> ADD lasts 3 cycles, done in T+7; add_a/add_b constant during ADD.
- reset=0 asserted in the cycle the controller is in WB -> rf_we=0, no done, rf[31] unchanged; cmd_ready=1 the cycle after reset returns high.
- src_a=src_b=dst=4, rf[4]=0x3F800000 -> done_data=0x40000000, rf[4]=0x40000000.
- With FPSEQ_EXC_FLAG_EN: rf[1]=0x7F7FFFFF, rf[2]=0x7F7FFFFF -> exc=1 with done, exc_count=1; a finite sum next -> exc=0, exc_count stays 1.
